rr_arbiter4: RTL

Round-robin arbiter that shares one resource among N requesters with registered one-hot grants and a bounded grant tenure. It extends the two-requester fixed-priority grant scheme to N requesters with fairness. A requester can no longer starve the others: a tenure counter forces handover after `MAX_HOLD` cycles whenever another request is pending. It sits between the requesting engines and the shared resource, and its grant vector drives the resource's input mux select.

---
 rtl/rr_arbiter4.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/rr_arbiter4.sv
// rtl/rr_arbiter4.sv - N-way round-robin arbiter with registered one-hot grants and bounded tenure
module rr_arbiter4 #(
    parameter int N        = 4,
    parameter int MAX_HOLD = 8,
    localparam int IDW     = (N > 1) ? $clog2(N) : 1,
    localparam int TW      = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [N-1:0]   req,
    output logic [N-1:0]   gnt,
    output logic [IDW-1:0] gnt_id,
    output logic           busy
);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_t;

    localparam logic [N-1:0]   ONE_HOT0 = {{(N-1){1'b0}}, 1'b1};
    localparam logic [TW-1:0]  TEN_MAX  = TW'(MAX_HOLD);
    localparam logic [IDW-1:0] LAST_IDX = IDW'(N - 1);

    state_t         r_state;
    logic [N-1:0]   r_gnt;
    logic [IDW-1:0] r_gnt_id;
    logic           r_busy;
    logic [IDW-1:0] r_ptr;
    logic [TW-1:0]  r_tenure;

    state_t         w_state_nxt;
    logic [N-1:0]   w_gnt_nxt;
    logic [IDW-1:0] w_gnt_id_nxt;
    logic [IDW-1:0] w_ptr_nxt;
    logic [TW-1:0]  w_tenure_nxt;

    logic [N-1:0]   w_owner_mask;
    logic [N-1:0]   w_others;
    logic           w_owner_req;
    logic [IDW:0]   w_pick_all;
    logic [IDW:0]   w_pick_masked;
    logic           w_do_grant;
    logic [IDW-1:0] w_grant_idx;

    // Returns {found, index} of the first set bit of r scanning p, p+1, ... mod N.
    function automatic logic [IDW:0] rr_pick(input logic [N-1:0] r, input logic [IDW-1:0] p);
        logic           found;
        logic [IDW-1:0] idx;
        int             j;
        found = 1'b0;
        idx   = '0;
        for (int i = 0; i < N; i++) begin
            j = (int'(p) + i) % N;
            if (!found && r[j]) begin
                found = 1'b1;
                idx   = IDW'(j);
            end
        end
        return {found, idx};
    endfunction

    // The current owner's bit, and the requests competing against it.
    always_comb begin
        w_owner_mask  = ONE_HOT0 << r_gnt_id;
        w_others      = req & ~w_owner_mask;
        w_owner_req   = |(req & w_owner_mask);
        w_pick_all    = rr_pick(req, r_ptr);
        w_pick_masked = rr_pick(w_others, r_ptr);
    end

    // Next-state decision: idle entry, release handover, forced handover or hold.
    always_comb begin
        w_state_nxt  = r_state;
        w_gnt_nxt    = r_gnt;
        w_gnt_id_nxt = r_gnt_id;
        w_ptr_nxt    = r_ptr;
        w_tenure_nxt = r_tenure;
        w_do_grant   = 1'b0;
        w_grant_idx  = w_pick_all[IDW-1:0];

        case (r_state)
            ST_IDLE: begin
                w_gnt_nxt = '0;
                if (|req) begin
                    w_do_grant  = 1'b1;
                    w_state_nxt = ST_GRANT;
                end
            end
            ST_GRANT: begin
                if (!w_owner_req) begin
                    // Owner released: hand over in the same edge, or go idle.
                    if (|req) begin
                        w_do_grant = 1'b1;
                    end else begin
                        w_gnt_nxt    = '0;
                        w_tenure_nxt = '0;
                        w_state_nxt  = ST_IDLE;
                    end
                end else if ((r_tenure == TEN_MAX) && (|w_others)) begin
                    // Tenure exhausted with contention: owner excluded from the search.
                    w_do_grant  = 1'b1;
                    w_grant_idx = w_pick_masked[IDW-1:0];
                end else if (r_tenure != TEN_MAX) begin
                    w_tenure_nxt = r_tenure + TW'(1);
                end
            end
            default: begin
                w_gnt_nxt   = '0;
                w_state_nxt = ST_IDLE;
            end
        endcase

        if (w_do_grant) begin
            w_gnt_nxt    = ONE_HOT0 << w_grant_idx;
            w_gnt_id_nxt = w_grant_idx;
            w_ptr_nxt    = (w_grant_idx == LAST_IDX) ? '0 : (w_grant_idx + IDW'(1));
            w_tenure_nxt = TW'(1);
        end
    end

    // State register; reset clears grants immediately without waiting for a clock.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state  <= ST_IDLE;
            r_gnt    <= '0;
            r_gnt_id <= '0;
            r_busy   <= 1'b0;
            r_ptr    <= '0;
            r_tenure <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_gnt    <= w_gnt_nxt;
            r_gnt_id <= w_gnt_id_nxt;
            r_busy   <= |w_gnt_nxt;
            r_ptr    <= w_ptr_nxt;
            r_tenure <= w_tenure_nxt;
        end
    end

    assign gnt    = r_gnt;
    assign gnt_id = r_gnt_id;
    assign busy   = r_busy;

endmodule
